delay_tap_cal: RTL and testbench

Measures the latency, in clock cycles, from a trigger strobe to the first threshold crossing on a 13-bit signed sample stream. It averages 2^AVG_LOG2 shots and converts the result into a 5-bit tap setting for the variable-tap delay line, so that total latency equals TARGET. It is the controller end of the tap interface: it produces the `tap` value that the delay line consumes. It runs once per `start`, and holds the last good tap between calibrations.

---
 rtl/delay_tap_cal.sv | 83 ++++++++
 tb/tb_delay_tap_cal.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/delay_tap_cal.sv
// delay_tap_cal: measures trigger-to-crossing latency over several shots and derives a delay-line tap
module delay_tap_cal #(
  parameter int TARGET   = 16,
  parameter int AVG_LOG2 = 2,
  parameter int TIMEOUT  = 63,
  parameter int INIT_TAP = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               trig,
  input  logic signed [12:0] din,
  input  logic signed [12:0] threshold,
  output logic [4:0]         tap,
  output logic [5:0]         delay,
  output logic               busy,
  output logic               done,
  output logic               timeout_err
);
  localparam int AW = 6 + AVG_LOG2;
  localparam logic [AVG_LOG2:0] LAST = (AVG_LOG2 + 1)'((1 << AVG_LOG2) - 1);
  typedef enum logic [1:0] {IDLE, ARM, COUNT, COMPUTE} state_t;
  state_t st;
  logic [5:0] cnt;
  logic [AVG_LOG2:0] shots;
  logic [AW-1:0] acc;
  logic [5:0] avg;
  logic [4:0] tap_n;
  logic hit;
  // averaged delay, clamped tap and signed crossing detect
  always_comb begin
    avg = 6'(acc >> AVG_LOG2);
    tap_n = (int'(avg) >= TARGET) ? 5'd0 : (TARGET - int'(avg) > 31) ? 5'd31 : 5'(TARGET - int'(avg));
    hit = din >= threshold;
  end
  // calibration sequencer; tap only moves in COMPUTE so the delay line never sees partial results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= IDLE;
      cnt <= '0;
      shots <= '0;
      acc <= '0;
      tap <= 5'(INIT_TAP);
      delay <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      done <= 1'b0;
      case (st)
        IDLE: if (start) begin
          acc <= '0;
          shots <= '0;
          timeout_err <= 1'b0;
          busy <= 1'b1;
          st <= ARM;
        end
        ARM: if (trig) begin
          cnt <= 6'd1;
          st <= COUNT;
        end
        COUNT: if (hit) begin
          acc <= acc + AW'(cnt);
          shots <= shots + 1'b1;
          st <= (shots == LAST) ? COMPUTE : ARM;
        end else if (cnt == 6'(TIMEOUT)) begin
          timeout_err <= 1'b1;
          done <= 1'b1;
          busy <= 1'b0;
          st <= IDLE;
        end else cnt <= cnt + 6'd1;
        COMPUTE: begin
          delay <= avg;
          tap <= tap_n;
          done <= 1'b1;
          busy <= 1'b0;
          st <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_delay_tap_cal.sv
// tb_delay_tap_cal: randomized calibration runs checked every cycle against a transaction-level model
module tb_delay_tap_cal;
  logic clk = 0, rst_n, start, trig;
  logic signed [12:0] din, threshold;
  logic [4:0] tap, tap2;
  logic [5:0] delay, delay2;
  logic busy, busy2, done, done2, err, err2;
  int checks = 0, errors = 0, thr = 0;
  int exp_tap = 0, exp_tap2 = 3, exp_delay = 0, exp_busy = 0, exp_done = 0, exp_err = 0;

  delay_tap_cal #(.TARGET(16), .AVG_LOG2(2), .TIMEOUT(63), .INIT_TAP(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .trig(trig), .din(din), .threshold(threshold),
    .tap(tap), .delay(delay), .busy(busy), .done(done), .timeout_err(err));
  delay_tap_cal #(.TARGET(40), .AVG_LOG2(2), .TIMEOUT(63), .INIT_TAP(3)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .trig(trig), .din(din), .threshold(threshold),
    .tap(tap2), .delay(delay2), .busy(busy2), .done(done2), .timeout_err(err2));

  always #5 clk = ~clk;

  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", n, a, e, $time);
    end
  endtask

  function automatic int clamp(input int t, input int avg);
    return avg >= t ? 0 : (t - avg > 31 ? 31 : t - avg);
  endfunction

  function automatic logic signed [12:0] lo();
    int m;
    m = $urandom_range(0, 1) ? 1 : int'($urandom_range(1, 2000));
    return 13'(thr - m);
  endfunction

  function automatic logic signed [12:0] hi();
    int m;
    m = $urandom_range(0, 1) ? 0 : int'($urandom_range(1, 2000));
    return 13'(thr + m);
  endfunction

  always @(posedge clk) begin
    #1;
    chk("tap", tap, exp_tap);
    chk("tap2", tap2, exp_tap2);
    chk("delay", delay, exp_delay);
    chk("delay2", delay2, exp_delay);
    chk("busy", busy, exp_busy);
    chk("busy2", busy2, exp_busy);
    chk("done", done, exp_done);
    chk("done2", done2, exp_done);
    chk("err", err, exp_err);
    chk("err2", err2, exp_err);
  end

  task automatic chk_reset_now();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_tap", tap, 0);
    chk("rst_tap2", tap2, 3);
    chk("rst_delay", delay, 0);
    chk("rst_err", err2, 0);
  endtask

  // one calibration; a delay of 0 means that shot never crosses (timeout)
  task automatic calib(input int d0, d1, d2, d3, input int rs_shot, input int rs_k);
    int dl[4];
    int acc;
    dl = '{d0, d1, d2, d3};
    acc = 0;
    @(negedge clk);
    threshold = 13'(thr);
    start = 1;
    trig = 0;
    din = lo();
    exp_busy = 1;
    exp_err = 0;
    for (int s = 0; s < 4; s++) begin
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        start = ($urandom_range(0, 3) == 0);
        trig = 0;
        din = $urandom_range(0, 1) ? lo() : hi();
      end
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      trig = 1;
      din = lo();
      for (int k = 1; k <= 63; k++) begin
        @(negedge clk);
        start = ($urandom_range(0, 3) == 0);
        trig = $urandom_range(0, 1);
        din = (k == dl[s]) ? hi() : lo();
        if (s == rs_shot && k == rs_k) begin
          #2 rst_n = 0;
          exp_tap = 0; exp_tap2 = 3; exp_delay = 0; exp_busy = 0; exp_done = 0; exp_err = 0;
          #1 chk_reset_now();
          @(negedge clk);
          rst_n = 1; start = 0; trig = 0;
          return;
        end
        if (k == dl[s]) break;
        if (k == 63) begin
          exp_done = 1; exp_busy = 0; exp_err = 1;
          @(negedge clk);
          start = 0; trig = 0; exp_done = 0;
          return;
        end
      end
      acc += dl[s];
    end
    @(negedge clk);
    start = 0; trig = 0;
    exp_done = 1; exp_busy = 0;
    exp_delay = acc >> 2;
    exp_tap = clamp(16, acc >> 2);
    exp_tap2 = clamp(40, acc >> 2);
    @(negedge clk);
    exp_done = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    rst_n = 1; start = 0; trig = 0; din = 0; threshold = 0;
    #1 rst_n = 0;
    #2 chk_reset_now();
    repeat (3) @(negedge clk);
    rst_n = 1;
    thr = 100;
    calib(5, 5, 5, 5, -1, 0);
    chk("t1_tap", tap, 11);
    chk("t1_delay", delay, 5);
    calib(3, 4, 4, 6, -1, 0);
    chk("t2_tap", tap, 12);
    chk("t2_delay", delay, 4);
    calib(20, 20, 20, 20, -1, 0);
    chk("t3a_tap", tap, 0);
    chk("t3a_delay", delay, 20);
    calib(2, 2, 2, 2, -1, 0);
    chk("t3b_tap2", tap2, 31);
    calib(5, 5, 5, 5, -1, 0);
    calib(0, 5, 5, 5, -1, 0);
    chk("t4_tap", tap, 11);
    chk("t4_delay", delay, 5);
    chk("t4_err", err, 1);
    repeat (3) begin
      @(negedge clk);
      trig = 1;
      @(negedge clk);
      trig = 0;
    end
    thr = -700;
    calib(1, 1, 1, 1, -1, 0);
    chk("t5_tap", tap, 15);
    chk("t5_delay", delay, 1);
    chk("t5_err", err, 0);
    calib(5, 5, 5, 5, 2, 2);
    calib(7, 7, 7, 7, -1, 0);
    chk("t6_tap", tap, 9);
    for (int r = 0; r < 16; r++) begin
      int d[4];
      thr = int'($urandom_range(0, 4000)) - 2000;
      foreach (d[i]) d[i] = $urandom_range(1, 30);
      if ($urandom_range(0, 5) == 0) d[$urandom_range(0, 3)] = 0;
      calib(d[0], d[1], d[2], d[3], -1, 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
